branch_predictor_gshare_btb: RTL and testbench

- Parametrised successor to the fetch-stage 4-entry BTB/2-bit predictor.
- Sits between the fetch and execute stages. Provides a combinational taken/target prediction for the current fetch PC and resolves the prediction in execute.
- Adds configurable depth, counter width, valid bits, an optional gshare index mode, execute-time allocation, target-mismatch detection, and invalidation of stale entries.

---
 rtl/branch_predictor_gshare_btb_if.sv | 32 +++
 rtl/branch_predictor_gshare_btb.sv | 126 ++++++++++++
 tb/tb_branch_predictor_gshare_btb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_gshare_btb_if.sv
// rtl/branch_predictor_gshare_btb_if.sv - fetch/execute signal bundle for the gshare BTB predictor
interface branch_predictor_gshare_btb_if #(
    parameter int GHR_BITS = 4
);
    logic [31:0]         i_pcF;
    logic                o_predTakenF;
    logic [31:0]         o_predTargetF;
    logic [GHR_BITS-1:0] o_ghrF;
    logic                i_validE;
    logic [31:0]         i_pcE;
    logic                i_branchE;
    logic                i_jumpE;
    logic                i_takenE;
    logic [31:0]         i_targetE;
    logic                i_predTakenE;
    logic [31:0]         i_predTargetE;
    logic [GHR_BITS-1:0] i_ghrE;
    logic                o_mispredictE;
    logic [31:0]         o_redirectPCE;

    modport master (
        output i_pcF, i_validE, i_pcE, i_branchE, i_jumpE, i_takenE,
               i_targetE, i_predTakenE, i_predTargetE, i_ghrE,
        input  o_predTakenF, o_predTargetF, o_ghrF, o_mispredictE, o_redirectPCE
    );

    modport slave (
        input  i_pcF, i_validE, i_pcE, i_branchE, i_jumpE, i_takenE,
               i_targetE, i_predTakenE, i_predTargetE, i_ghrE,
        output o_predTakenF, o_predTargetF, o_ghrF, o_mispredictE, o_redirectPCE
    );
endinterface

// File: rtl/branch_predictor_gshare_btb.sv
// rtl/branch_predictor_gshare_btb.sv - BTB with saturating counters and optional gshare indexing
module branch_predictor_gshare_btb #(
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 4,
    parameter int GSHARE     = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    branch_predictor_gshare_btb_if.slave  bus
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [CTR_BITS-1:0]   ctr_t;
    typedef logic [GHR_BITS-1:0]   ghr_t;

    logic [ENTRIES-1:0] valid_q, valid_d;
    tag_t               tag_q    [ENTRIES];
    tag_t               tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];
    ctr_t               ctr_d    [ENTRIES];
    ghr_t               ghr_q, ghr_d;

    idx_t idx_f, idx_e;
    logic hit_f, hit_e, pred_taken_f, act_taken, is_cf;
    logic unused_pc_bits;

    assign unused_pc_bits = &{1'b0, bus.i_pcF[1:0]};

    // Fetch and execute share one index function so carried GHR reproduces the fetch slot
    function automatic idx_t index_of(input logic [31:0] pc, input ghr_t ghr);
        idx_t hist;
        hist = (GSHARE != 0) ? idx_t'(ghr) : '0;
        return pc[INDEX_BITS+1:2] ^ hist;
    endfunction

    // Fetch-side lookup: reads pre-update table state, no bypass from execute
    always_comb begin
        idx_f             = index_of(bus.i_pcF, ghr_q);
        hit_f             = valid_q[idx_f] && (tag_q[idx_f] == bus.i_pcF[31:INDEX_BITS+2]);
        pred_taken_f      = hit_f && ctr_q[idx_f][CTR_BITS-1];
        bus.o_predTakenF  = pred_taken_f;
        bus.o_predTargetF = pred_taken_f ? target_q[idx_f] : 32'd0;
        bus.o_ghrF        = ghr_q;
    end

    // Execute-side resolve: mispredict detection and next table/history contents
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        ghr_d     = ghr_q;
        act_taken = bus.i_jumpE | (bus.i_branchE & bus.i_takenE);
        is_cf     = bus.i_branchE | bus.i_jumpE;
        idx_e     = index_of(bus.i_pcE, bus.i_ghrE);
        hit_e     = valid_q[idx_e] && (tag_q[idx_e] == bus.i_pcE[31:INDEX_BITS+2]);
        bus.o_mispredictE = 1'b0;
        bus.o_redirectPCE = act_taken ? bus.i_targetE : bus.i_pcE + 32'd4;

        if (bus.i_validE && !i_rst) begin
            if (is_cf) begin
                bus.o_mispredictE = (bus.i_predTakenE != act_taken) ||
                                    (act_taken && bus.i_predTakenE &&
                                     (bus.i_predTargetE != bus.i_targetE));
            end else begin
                bus.o_mispredictE = bus.i_predTakenE;
            end

            if (!is_cf) begin
                // A non-branch predicted taken means the entry is stale or aliased
                if (bus.i_predTakenE) begin
                    valid_d[idx_e] = 1'b0;
                end
            end else if (bus.i_jumpE) begin
                // Hit or miss, a jump leaves the slot owned by it and strongly taken
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = bus.i_pcE[31:INDEX_BITS+2];
                target_d[idx_e] = bus.i_targetE;
                ctr_d[idx_e]    = '1;
            end else if (hit_e) begin
                if (bus.i_takenE) begin
                    target_d[idx_e] = bus.i_targetE;
                    if (ctr_q[idx_e] != '1) begin
                        ctr_d[idx_e] = ctr_q[idx_e] + ctr_t'(1);
                    end
                end else if (ctr_q[idx_e] != '0) begin
                    ctr_d[idx_e] = ctr_q[idx_e] - ctr_t'(1);
                end
            end else if (bus.i_takenE) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = bus.i_pcE[31:INDEX_BITS+2];
                target_d[idx_e] = bus.i_targetE;
                ctr_d[idx_e]    = ctr_t'(1) << (CTR_BITS - 1);
            end

            if (bus.i_branchE) begin
                ghr_d = ghr_t'({ghr_q, bus.i_takenE});
            end
        end
    end

    // Table and history registers with synchronous clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            ghr_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            ghr_q    <= ghr_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor_gshare_btb.sv
// tb/tb_branch_predictor_gshare_btb.sv - bimodal and gshare predictors against a behavioural model
module tb_branch_predictor_gshare_btb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] pcF, pcE, targetE, predTargetE;
    logic        validE, branchE, jumpE, takenE, predTakenE;
    logic [3:0]  ghrE0, ghrE1;

    branch_predictor_gshare_btb_if #(.GHR_BITS(4)) bif0 ();
    branch_predictor_gshare_btb_if #(.GHR_BITS(4)) bif1 ();

    assign bif0.i_pcF = pcF;          assign bif1.i_pcF = pcF;
    assign bif0.i_validE = validE;    assign bif1.i_validE = validE;
    assign bif0.i_pcE = pcE;          assign bif1.i_pcE = pcE;
    assign bif0.i_branchE = branchE;  assign bif1.i_branchE = branchE;
    assign bif0.i_jumpE = jumpE;      assign bif1.i_jumpE = jumpE;
    assign bif0.i_takenE = takenE;    assign bif1.i_takenE = takenE;
    assign bif0.i_targetE = targetE;  assign bif1.i_targetE = targetE;
    assign bif0.i_predTakenE = predTakenE;   assign bif1.i_predTakenE = predTakenE;
    assign bif0.i_predTargetE = predTargetE; assign bif1.i_predTargetE = predTargetE;
    assign bif0.i_ghrE = ghrE0;       assign bif1.i_ghrE = ghrE1;

    branch_predictor_gshare_btb #(.INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .GSHARE(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bif0.slave));
    branch_predictor_gshare_btb #(.INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .GSHARE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bif1.slave));

    int checks = 0;
    int errors = 0;

    // Model: per instance, 16 entries with integer counters 0..3
    bit          m_valid [2][16];
    logic [31:0] m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    int          m_ctr   [2][16];
    logic [3:0]  m_ghr   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int midx(input int m, input logic [31:0] pc, input logic [3:0] g);
        int base;
        base = int'((pc >> 2) & 32'hF);
        return (m == 1) ? (base ^ int'(g)) : base;
    endfunction

    function automatic void mpred(input int m, input logic [31:0] pc,
                                  output logic t, output logic [31:0] tg);
        int i;
        i  = midx(m, pc, m_ghr[m]);
        t  = m_valid[m][i] && (m_tag[m][i] == (pc >> 6)) && (m_ctr[m][i] >= 2);
        tg = t ? m_tgt[m][i] : 32'd0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ghr[m] = 4'd0;
            for (int i = 0; i < 16; i++) begin
                m_valid[m][i] = 1'b0; m_tag[m][i] = '0; m_tgt[m][i] = '0; m_ctr[m][i] = 0;
            end
        end
    endtask

    task automatic model_update();
        int i;
        bit hit;
        if (rst) begin
            model_reset();
            return;
        end
        if (!validE) return;
        for (int m = 0; m < 2; m++) begin
            i   = midx(m, pcE, (m == 1) ? ghrE1 : ghrE0);
            hit = m_valid[m][i] && (m_tag[m][i] == (pcE >> 6));
            if (!branchE && !jumpE) begin
                if (predTakenE) m_valid[m][i] = 1'b0;
            end else if (jumpE || (!hit && takenE)) begin
                m_valid[m][i] = 1'b1;
                m_tag[m][i]   = pcE >> 6;
                m_tgt[m][i]   = targetE;
                m_ctr[m][i]   = jumpE ? 3 : 2;
            end else if (hit) begin
                if (takenE) begin
                    m_ctr[m][i] = (m_ctr[m][i] == 3) ? 3 : m_ctr[m][i] + 1;
                    m_tgt[m][i] = targetE;
                end else begin
                    m_ctr[m][i] = (m_ctr[m][i] == 0) ? 0 : m_ctr[m][i] - 1;
                end
            end
            if (branchE) m_ghr[m] = {m_ghr[m][2:0], takenE};
        end
    endtask

    task automatic compare_all();
        logic et, emp, act;
        logic [31:0] etg, erd;
        act = jumpE | (branchE & takenE);
        if (!validE || rst)          emp = 1'b0;
        else if (branchE || jumpE)   emp = (predTakenE != act) || (act && predTakenE && predTargetE != targetE);
        else                         emp = predTakenE;
        erd = act ? targetE : pcE + 32'd4;
        for (int m = 0; m < 2; m++) begin
            mpred(m, pcF, et, etg);
            chk($sformatf("m%0d predTakenF pc=%h", m, pcF),
                32'(m == 1 ? bif1.o_predTakenF : bif0.o_predTakenF), 32'(et));
            chk($sformatf("m%0d predTargetF pc=%h", m, pcF),
                m == 1 ? bif1.o_predTargetF : bif0.o_predTargetF, etg);
            chk($sformatf("m%0d ghrF", m), 32'(m == 1 ? bif1.o_ghrF : bif0.o_ghrF), 32'(m_ghr[m]));
            chk($sformatf("m%0d mispredictE pc=%h", m, pcE),
                32'(m == 1 ? bif1.o_mispredictE : bif0.o_mispredictE), 32'(emp));
            if (emp) chk($sformatf("m%0d redirectPCE pc=%h", m, pcE),
                         m == 1 ? bif1.o_redirectPCE : bif0.o_redirectPCE, erd);
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc);
        pcF = fpc; validE = 1'b0; branchE = 1'b0; jumpE = 1'b0; takenE = 1'b0;
        predTakenE = 1'b0; predTargetE = '0; pcE = '0; targetE = '0;
        ghrE0 = m_ghr[0]; ghrE1 = m_ghr[1];
        #1;
    endtask

    // kind: 0 non-branch, 1 branch, 2 jump
    task automatic exe(input int kind, input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic pt, input logic [31:0] ptg);
        validE = 1'b1; pcE = pc; branchE = (kind == 1); jumpE = (kind == 2); takenE = tk;
        targetE = tg; predTakenE = pt; predTargetE = ptg;
        ghrE0 = m_ghr[0]; ghrE1 = m_ghr[1];
        #1;
    endtask

    initial begin
        logic pt;
        logic [31:0] ptg, p;
        int kind;
        model_reset();
        rst = 1'b1;
        idle(32'h100);
        exe(1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("mispredict held low in reset", 32'(bif0.o_mispredictE), 32'd0);
        step();
        rst = 1'b0;
        idle(32'h100);
        chk("reset predTaken", 32'(bif0.o_predTakenF), 32'd0);
        chk("reset predTarget", bif0.o_predTargetF, 32'd0);
        chk("reset ghr", 32'(bif0.o_ghrF), 32'd0);
        step();

        // Allocate, weaken, saturate, retrain, target fix
        exe(1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("alloc mispredict", 32'(bif0.o_mispredictE), 32'd1);
        chk("alloc redirect", bif0.o_redirectPCE, 32'h80);
        step();
        idle(32'h40);
        chk("alloc visible taken", 32'(bif0.o_predTakenF), 32'd1);
        chk("alloc visible target", bif0.o_predTargetF, 32'h80);
        step();
        exe(1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
        chk("not-taken mispredict", 32'(bif0.o_mispredictE), 32'd1);
        chk("not-taken redirect", bif0.o_redirectPCE, 32'h44);
        step();
        idle(32'h40);
        chk("ctr1 not taken", 32'(bif0.o_predTakenF), 32'd0);
        step();
        exe(1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h0);
        chk("correct not-taken", 32'(bif0.o_mispredictE), 32'd0);
        step();
        exe(1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h0);
        step();
        exe(1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        step();
        idle(32'h40);
        chk("saturated at 0 then +1", 32'(bif0.o_predTakenF), 32'd0);
        step();
        exe(1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        step();
        exe(1, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80);
        chk("target mismatch", 32'(bif0.o_mispredictE), 32'd1);
        chk("target mismatch redirect", bif0.o_redirectPCE, 32'h90);
        step();
        idle(32'h40);
        chk("retargeted", bif0.o_predTargetF, 32'h90);
        step();

        // Jump allocation, alias miss, stale invalidation
        exe(2, 32'h200, 1'b0, 32'h400, 1'b0, 32'h0);
        chk("jump redirect", bif0.o_redirectPCE, 32'h400);
        step();
        idle(32'h200);
        chk("jump hit", bif0.o_predTargetF, 32'h400);
        step();
        idle(32'h300);
        chk("alias miss", 32'(bif0.o_predTakenF), 32'd0);
        step();
        exe(0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h400);
        chk("stale mispredict", 32'(bif0.o_mispredictE), 32'd1);
        chk("stale redirect", bif0.o_redirectPCE, 32'h204);
        step();
        idle(32'h200);
        chk("stale invalidated", 32'(bif0.o_predTakenF), 32'd0);
        step();

        // Gshare history steering
        rst = 1'b1;
        idle(32'h0);
        step();
        rst = 1'b0;
        exe(1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);   step();
        exe(1, 32'h1004, 1'b1, 32'h80, 1'b0, 32'h0); step();
        exe(1, 32'h1008, 1'b1, 32'h80, 1'b0, 32'h0); step();
        exe(1, 32'h100C, 1'b1, 32'h80, 1'b0, 32'h0); step();
        idle(32'h40);
        chk("gshare ghr full", 32'(bif1.o_ghrF), 32'hF);
        chk("gshare no hit", 32'(bif1.o_predTakenF), 32'd0);
        chk("bimodal still hits", bif0.o_predTargetF, 32'h80);
        step();

        // Randomised traffic over a small aliasing PC set
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            pcF = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            p   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            mpred(0, p, pt, ptg);
            if ($urandom_range(0, 4) == 0) pt = ~pt;
            if ($urandom_range(0, 4) == 0) ptg = $urandom_range(0, 255) << 2;
            kind = $urandom_range(0, 5);
            kind = (kind < 1) ? 0 : (kind < 5) ? 1 : 2;
            case ($urandom_range(0, 3))
                0: targetE = 32'h80;
                1: targetE = 32'h90;
                2: targetE = 32'h400;
                default: targetE = $urandom & 32'hFFFF_FFFC;
            endcase
            exe(kind, p, 1'($urandom_range(0, 1)), targetE, pt, ptg);
            validE = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) == 0) pcE = 32'hFFFF_FFFC;
            #1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
